// File: rtl/ycbcr_pkg.sv
//============================================================================
// ycbcr_pkg - shared coefficients, offsets and config encodings | rev 1.0
//============================================================================
`default_nettype none

package ycbcr_pkg;

  typedef logic signed [8:0] coef_t;

  // Rows: Y, Cb, Cr. Columns: R, G, B. Q0.8 fixed point.
  localparam coef_t COEF_601 [3][3] = '{
    '{ 9'sd66,   9'sd129,  9'sd25 },
    '{-9'sd38,  -9'sd74,   9'sd112},
    '{ 9'sd112, -9'sd94,  -9'sd18 }
  };
  localparam coef_t COEF_709 [3][3] = '{
    '{ 9'sd47,   9'sd157,  9'sd16 },
    '{-9'sd26,  -9'sd87,   9'sd112},
    '{ 9'sd112, -9'sd102, -9'sd10 }
  };

  localparam logic STD_601 = 1'b0;
  localparam logic STD_709 = 1'b1;
  localparam logic FMT_444 = 1'b0;
  localparam logic FMT_422 = 1'b1;

  localparam int Y_OFS8  = 16;
  localparam int C_OFS8  = 128;
  localparam int ROUND_K = 128;

  typedef struct packed {
    logic std;
    logic fmt;
  } cfg_t;

  localparam cfg_t CFG_RST = '{std: STD_601, fmt: FMT_444};

endpackage

`default_nettype wire

// File: rtl/ycbcr_matrix_stage.sv
//============================================================================
// ycbcr_matrix_stage - products (S1) and rounded row sums (S2) | rev 1.0
//============================================================================
`default_nettype none

module ycbcr_matrix_stage
  import ycbcr_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = DW + 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_valid,
  input  logic                   i_sol,
  input  logic                   i_std,
  input  logic                   i_fmt,
  input  logic [DW-1:0]          i_r,
  input  logic [DW-1:0]          i_g,
  input  logic [DW-1:0]          i_b,
  output logic                   o_valid,
  output logic                   o_sol,
  output logic                   o_fmt,
  output logic signed [ACCW-1:0] o_sum_y,
  output logic signed [ACCW-1:0] o_sum_cb,
  output logic signed [ACCW-1:0] o_sum_cr
);

  localparam logic signed [ACCW-1:0] C_RND = ACCW'(ROUND_K);

  logic [DW-1:0]          w_pix  [3];
  logic signed [ACCW-1:0] w_prod [3][3];
  logic signed [ACCW-1:0] r_prod [3][3];
  logic signed [ACCW-1:0] r_sum  [3];
  logic                   r_s1_valid, r_s1_sol, r_s1_fmt;
  logic                   r_s2_valid, r_s2_sol, r_s2_fmt;

  assign w_pix = '{i_r, i_g, i_b};

  // Samples are unsigned, so they are zero-extended before the signed multiply.
  always_comb begin : p_products
    coef_t                  c;
    logic signed [ACCW-1:0] c_ext;
    logic signed [ACCW-1:0] s_ext;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        c            = (i_std == STD_709) ? COEF_709[k][j] : COEF_601[k][j];
        c_ext        = {{(ACCW-9){c[8]}}, c};
        s_ext        = {{(ACCW-DW){1'b0}}, w_pix[j]};
        w_prod[k][j] = c_ext * s_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        r_sum[k] <= '0;
        for (int j = 0; j < 3; j++) r_prod[k][j] <= '0;
      end
      r_s1_valid <= 1'b0;
      r_s1_sol   <= 1'b0;
      r_s1_fmt   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_sol   <= 1'b0;
      r_s2_fmt   <= 1'b0;
    end else if (i_en) begin
      for (int k = 0; k < 3; k++) begin
        r_sum[k] <= r_prod[k][0] + r_prod[k][1] + r_prod[k][2] + C_RND;
        for (int j = 0; j < 3; j++) r_prod[k][j] <= w_prod[k][j];
      end
      r_s1_valid <= i_valid;
      r_s1_sol   <= i_sol;
      r_s1_fmt   <= i_fmt;
      r_s2_valid <= r_s1_valid;
      r_s2_sol   <= r_s1_sol;
      r_s2_fmt   <= r_s1_fmt;
    end
  end

  assign o_valid  = r_s2_valid;
  assign o_sol    = r_s2_sol;
  assign o_fmt    = r_s2_fmt;
  assign o_sum_y  = r_sum[0];
  assign o_sum_cb = r_sum[1];
  assign o_sum_cr = r_sum[2];

endmodule

`default_nettype wire

// File: rtl/rgb_ycbcr_pipe.sv
//============================================================================
// rgb_ycbcr_pipe - 3-stage RGB->YCbCr converter, BT.601/709, 4:2:2 option | rev 1.0
//============================================================================
`default_nettype none

module rgb_ycbcr_pipe
  import ycbcr_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = DW + 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sol,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_g,
  input  logic [DW-1:0] in_b,
  input  logic          std_sel,
  input  logic          sub422_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sol,
  output logic [DW-1:0] out_y,
  output logic [DW-1:0] out_c0,
  output logic [DW-1:0] out_c1,
  output logic          out_cphase
);

  localparam logic [DW-1:0]          C_Y_OFS = DW'(Y_OFS8 << (DW-8));
  localparam logic [DW-1:0]          C_C_OFS = DW'(C_OFS8 << (DW-8));
  localparam logic signed [ACCW-1:0] C_MAXV  = {{(ACCW-DW){1'b0}}, {DW{1'b1}}};

  logic                   w_en, w_acc, w_px_sol;
  cfg_t                   r_cfg, w_cfg_px;
  logic                   w_s2_valid, w_s2_sol, w_s2_fmt;
  logic signed [ACCW-1:0] w_sum_y, w_sum_cb, w_sum_cr;
  logic [DW-1:0]          w_y, w_cb, w_cr, w_c0, w_c1, w_held_now;
  logic                   w_hs, w_phase_now, w_ph, w_cph;
  logic                   r_out_valid, r_out_sol, r_out_422, r_out_cphase;
  logic [DW-1:0]          r_out_y, r_out_c0, r_out_c1, r_cr_keep, r_held_cr;
  logic                   r_phase;

  function automatic logic [DW-1:0] f_finish(input logic signed [ACCW-1:0] sum,
                                             input logic [DW-1:0] ofs);
    logic signed [ACCW-1:0] v;
    v = (sum >>> 8) + $signed({{(ACCW-DW){1'b0}}, ofs});
    if (v[ACCW-1])      f_finish = '0;
    else if (v > C_MAXV) f_finish = '1;
    else                 f_finish = v[DW-1:0];
  endfunction

  assign w_en     = ~r_out_valid | out_ready;
  assign in_ready = w_en;
  assign w_acc    = in_valid & w_en;
  assign w_px_sol = in_valid & in_sol;
  assign w_cfg_px = w_px_sol ? cfg_t'({std_sel, sub422_en}) : r_cfg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_cfg <= CFG_RST;
    else if (w_acc && in_sol) r_cfg <= w_cfg_px;
  end

  ycbcr_matrix_stage #(.DW(DW), .ACCW(ACCW)) u_matrix (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_en),
    .i_valid  (in_valid),
    .i_sol    (w_px_sol),
    .i_std    (w_cfg_px.std),
    .i_fmt    (w_cfg_px.fmt),
    .i_r      (in_r),
    .i_g      (in_g),
    .i_b      (in_b),
    .o_valid  (w_s2_valid),
    .o_sol    (w_s2_sol),
    .o_fmt    (w_s2_fmt),
    .o_sum_y  (w_sum_y),
    .o_sum_cb (w_sum_cb),
    .o_sum_cr (w_sum_cr)
  );

  assign w_y  = f_finish(w_sum_y,  C_Y_OFS);
  assign w_cb = f_finish(w_sum_cb, C_C_OFS);
  assign w_cr = f_finish(w_sum_cr, C_C_OFS);

  // The pixel entering S3 sees phase/held-Cr as they will be after this cycle's handshake.
  assign w_hs        = r_out_valid & out_ready;
  assign w_phase_now = (w_hs && r_out_422) ? ~r_out_cphase : r_phase;
  assign w_held_now  = (w_hs && r_out_422 && !r_out_cphase) ? r_cr_keep : r_held_cr;
  assign w_ph        = w_s2_sol ? 1'b0 : w_phase_now;

  always_comb begin
    w_c0  = w_cb;
    w_c1  = w_cr;
    w_cph = 1'b0;
    if (w_s2_fmt == FMT_422) begin
      w_c0  = w_ph ? w_held_now : w_cb;
      w_c1  = '0;
      w_cph = w_ph;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_sol    <= 1'b0;
      r_out_422    <= 1'b0;
      r_out_cphase <= 1'b0;
      r_out_y      <= '0;
      r_out_c0     <= '0;
      r_out_c1     <= '0;
      r_cr_keep    <= '0;
      r_held_cr    <= '0;
      r_phase      <= 1'b0;
    end else begin
      if (w_en) begin
        r_out_valid  <= w_s2_valid;
        r_out_sol    <= w_s2_sol;
        r_out_422    <= (w_s2_fmt == FMT_422);
        r_out_cphase <= w_cph;
        r_out_y      <= w_y;
        r_out_c0     <= w_c0;
        r_out_c1     <= w_c1;
        r_cr_keep    <= w_cr;
      end
      r_phase   <= w_phase_now;
      r_held_cr <= w_held_now;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sol    = r_out_sol;
  assign out_y      = r_out_y;
  assign out_c0     = r_out_c0;
  assign out_c1     = r_out_c1;
  assign out_cphase = r_out_cphase;

endmodule

`default_nettype wire

// File: tb/tb_rgb_ycbcr_pipe.sv
//============================================================================
// tb_rgb_ycbcr_pipe - directed checks of rgb_ycbcr_pipe (DW=8 and DW=10) | rev 1.0
//============================================================================
`default_nettype none

module tb_rgb_ycbcr_pipe;

  typedef struct {
    int     y, c0, c1, cph, sol;
    longint cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DW = 8 instance
  logic       in_valid = 1'b0, in_sol = 1'b0, std_sel = 1'b0, sub422_en = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic       in_ready, out_valid, out_sol, out_cphase;
  logic       out_ready = 1'b1;
  logic [7:0] out_y, out_c0, out_c1;

  // DW = 10 instance
  logic       v10 = 1'b0, sol10 = 1'b0, std10 = 1'b0, f10 = 1'b0, ordy10 = 1'b1;
  logic [9:0] r10 = '0, g10 = '0, b10 = '0;
  logic       irdy10, ov10, osol10, ocph10;
  logic [9:0] oy10, oc0_10, oc1_10;

  int     n_total = 0;
  int     n_bad   = 0;
  longint cyc     = 0;
  longint acc_cyc = 0;
  obs_t   q8[$];
  obs_t   q10[$];

  rgb_ycbcr_pipe #(.DW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .std_sel(std_sel), .sub422_en(sub422_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_sol(out_sol), .out_y(out_y),
    .out_c0(out_c0), .out_c1(out_c1), .out_cphase(out_cphase)
  );

  rgb_ycbcr_pipe #(.DW(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(v10), .in_ready(irdy10), .in_sol(sol10),
    .in_r(r10), .in_g(g10), .in_b(b10), .std_sel(std10), .sub422_en(f10),
    .out_valid(ov10), .out_ready(ordy10), .out_sol(osol10), .out_y(oy10),
    .out_c0(oc0_10), .out_c1(oc1_10), .out_cphase(ocph10)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready)
      q8.push_back('{y: int'(out_y), c0: int'(out_c0), c1: int'(out_c1),
                     cph: int'(out_cphase), sol: int'(out_sol), cyc: cyc});
    if (ov10 && ordy10)
      q10.push_back('{y: int'(oy10), c0: int'(oc0_10), c1: int'(oc1_10),
                      cph: int'(ocph10), sol: int'(osol10), cyc: cyc});
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int r, input int g, input int b,
                      input bit sol, input bit std, input bit f);
    int n;
    in_valid  = 1'b1;
    in_sol    = sol;
    in_r      = 8'(r);
    in_g      = 8'(g);
    in_b      = 8'(b);
    std_sel   = std;
    sub422_en = f;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic expect_px(input string tag, input int y, input int c0, input int c1,
                           input int cph, input int sol, output longint ocyc);
    obs_t o;
    ocyc = -1;
    if (q8.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      o    = q8.pop_front();
      ocyc = o.cyc;
      check({tag, "_y"},   o.y,   y);
      check({tag, "_c0"},  o.c0,  c0);
      check({tag, "_c1"},  o.c1,  c1);
      check({tag, "_cph"}, o.cph, cph);
      check({tag, "_sol"}, o.sol, sol);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Hand-computed DW=10 corners: black, white, red, green, blue.
  int ten_r [5] = '{0, 1023, 1023, 0, 0};
  int ten_g [5] = '{0, 1023, 0, 1023, 0};
  int ten_b [5] = '{0, 1023, 0, 0, 1023};
  int ten_y [5] = '{64, 943, 328, 579, 164};
  int ten_cb[5] = '{512, 512, 360, 216, 960};
  int ten_cr[5] = '{512, 512, 960, 136, 440};

  initial begin
    longint c_first, c_a, c_b, c_c, c_tmp;
    obs_t   o;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid",  out_valid,  0);
    check("rst_y",      out_y,      0);
    check("rst_c0",     out_c0,     0);
    check("rst_c1",     out_c1,     0);
    check("rst_cphase", out_cphase, 0);
    check("rst_sol",    out_sol,    0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    settle(2);

    // BT.601 4:4:4 black / white / red
    send(0, 0, 0, 1, 0, 0);
    c_first = acc_cyc;
    send(255, 255, 255, 0, 0, 0);
    send(255, 0, 0, 0, 0, 0);
    settle(6);
    expect_px("601_black", 16, 128, 128, 0, 1, c_tmp);
    check("latency", c_tmp - c_first, 3);
    expect_px("601_white", 235, 128, 128, 0, 0, c_tmp);
    expect_px("601_red",   82,  90,  240, 0, 0, c_tmp);

    // BT.709 line, non-sol pixel keeps 709, next sol switches back to 601
    send(255, 0, 0, 1, 1, 0);
    send(255, 0, 0, 0, 0, 0);
    send(255, 0, 0, 1, 0, 0);
    settle(6);
    expect_px("709_red",      63, 102, 240, 0, 1, c_tmp);
    expect_px("709_red_hold", 63, 102, 240, 0, 0, c_tmp);
    expect_px("601_red_back", 82, 90,  240, 0, 1, c_tmp);

    // 4:2:2 odd-length line, then a 4:4:4 line
    send(255, 0, 0, 1, 0, 1);
    send(255, 255, 255, 0, 0, 0);
    send(0, 0, 255, 0, 0, 0);
    send(0, 0, 0, 1, 0, 0);
    settle(6);
    expect_px("422_p0",   82,  90,  0,   0, 1, c_tmp);
    expect_px("422_p1",   235, 240, 0,   1, 0, c_tmp);
    expect_px("422_p2",   41,  240, 0,   0, 0, c_tmp);
    expect_px("444_next", 16,  128, 128, 0, 1, c_tmp);

    // Stall: three pixels in with out_ready low
    out_ready = 1'b0;
    send(0, 0, 0, 1, 0, 0);
    send(255, 255, 255, 0, 0, 0);
    send(255, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready",  in_ready,  0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_y",     out_y,     16);
    end
    check("stall_no_hs", q8.size(), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    settle(6);
    expect_px("rel_black", 16,  128, 128, 0, 1, c_a);
    expect_px("rel_white", 235, 128, 128, 0, 0, c_b);
    expect_px("rel_red",   82,  90,  240, 0, 0, c_c);
    check("rel_gap_1", c_b - c_a, 1);
    check("rel_gap_2", c_c - c_b, 1);

    // Reset mid 4:2:2 line with two pixels in flight
    send(255, 0, 0, 1, 0, 1);
    send(255, 255, 255, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_y",     out_y,     0);
    check("midrst_c0",    out_c0,    0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    settle(5);
    check("midrst_lost", q8.size(), 0);
    send(0, 255, 0, 1, 1, 1);
    send(0, 0, 255, 0, 0, 0);
    settle(6);
    expect_px("post_rst_p0", 172, 41, 0, 0, 1, c_tmp);
    expect_px("post_rst_p1", 32,  26, 0, 1, 0, c_tmp);

    // DW=10 corners, back to back
    for (int i = 0; i < 5; i++) begin
      v10   = 1'b1;
      sol10 = (i == 0);
      r10   = 10'(ten_r[i]);
      g10   = 10'(ten_g[i]);
      b10   = 10'(ten_b[i]);
      @(posedge clk);
      #1;
    end
    v10   = 1'b0;
    sol10 = 1'b0;
    settle(6);
    for (int i = 0; i < 5; i++) begin
      if (q10.size() == 0) begin
        check($sformatf("dw10_%0d_present", i), 0, 1);
      end else begin
        o = q10.pop_front();
        check($sformatf("dw10_%0d_y", i),  o.y,  ten_y[i]);
        check($sformatf("dw10_%0d_cb", i), o.c0, ten_cb[i]);
        check($sformatf("dw10_%0d_cr", i), o.c1, ten_cr[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
